rv_uart_fifo: RTL and testbench
===============================

RV_UART_FIFO -- requirements
Module: rv_uart_fifo

Interface
REQ-001 Parameter DATA_BITS, default 8, frame data width; legal values 5..8.
REQ-002 Parameter FIFO_DEPTH, default 4, RX FIFO entries; power of two, 2..16.
REQ-003 Parameter DIV_W, default 16, divisor width.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  reset rst, synchronous, active-high.
REQ-006 divisor  in  DIV_W  bit period minus one, in clk cycles.
REQ-007 parity_en / parity_odd / two_stop  in  1 each  frame format; sampled only at frame start.
REQ-008 tx_data  in  DATA_BITS  byte to send; tx_valid  in  1; tx_ready  out  1.
REQ-009 TX  out  1  serial output, idle high; RX  in  1  asynchronous serial input.
REQ-010 rx_data  out  DATA_BITS  FIFO head data; rx_perr, rx_ferr  out  1  head error flags.
REQ-011 rx_valid  out  1  FIFO non-empty; rx_ready  in  1  pop head.
REQ-012 rx_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-013 overrun  out  1  sticky lost-frame flag; clr_overrun  in  1  clears it.

Function
REQ-014 Bit period SHALL be divisor+1 clk cycles for TX and RX.
REQ-015 Frame: start(0), DATA_BITS data LSB first, optional parity, 1 or 2 stop(1).
REQ-016 Parity bit SHALL be XOR of data bits, inverted when parity_odd=1.
REQ-017 TX states: IDLE, START, DATA, PARITY, STOP1, STOP2; PARITY skipped if !parity_en, STOP2 skipped if !two_stop.
REQ-018 tx_ready SHALL be 1 only in IDLE; transfer occurs when tx_valid & tx_ready on a rising edge.
REQ-019 On transfer TX SHALL drive start bit from the next cycle; tx_data, mode bits latched at transfer.
REQ-020 After final stop period TX SHALL return to IDLE; tx_ready high next cycle, back-to-back frames allowed with no gap.
REQ-021 RX SHALL pass through a 2-flop synchroniser; start detected on synchronised 1->0 edge while RX FSM idle.
REQ-022 RX states: IDLE, START, DATA, PARITY, STOP1, STOP2(checked); sample taken at divisor>>1 cycles into each bit.
REQ-023 If start-bit sample is 1, RX SHALL return to IDLE without pushing (glitch reject).
REQ-024 rx_ferr for a frame SHALL be 1 if any checked stop sample is 0; rx_perr 1 on parity mismatch (0 if parity disabled).
REQ-025 Push SHALL occur at the stop-bit(s) sample point; RX FSM returns to IDLE then, allowing next start detection immediately.
REQ-026 Push to a full FIFO SHALL drop the frame and set overrun; a simultaneous pop and push on full SHALL succeed without overrun.
REQ-027 Pop on empty FIFO SHALL be ignored; rx_data/flags combinationally reflect head entry.
REQ-028 clr_overrun simultaneous with a new overrun event: overrun SHALL remain 1.
REQ-029 FIFO pointers SHALL wrap modulo FIFO_DEPTH; rx_count updates the cycle after push/pop.
REQ-030 divisor changed mid-frame: behaviour undefined; counters compare with current value.
REQ-031 divisor=0: one clk per bit, sampling at cycle 0 of each bit.

Reset
REQ-032 During rst: TX=1, tx_ready=0, both FSMs IDLE, counters 0, FIFO empty (rx_valid=0, rx_count=0), overrun=0, synchroniser flops=1.
REQ-033 rst asserted mid-frame SHALL abort TX/RX immediately; tx_ready=1 first cycle after rst release; no partial frame pushed.

Verification
REQ-034 divisor=3, 8N1, send 0xA5 -> TX low 4 cycles, then bits 1,0,1,0,0,1,0,1 each 4 cycles, stop high 4; tx_ready 0 for 40 cycles.
REQ-035 Loopback TX->RX, 8E2, divisor=7, send 0x3C -> rx_data=0x3C, rx_perr=0, rx_ferr=0, rx_count=1.
REQ-036 Drive RX frame 0x55 with stop=0, 8N1 -> rx_data=0x55, rx_ferr=1.
REQ-037 FIFO_DEPTH=4, receive 5 frames without pop -> rx_count=4, overrun=1, head=first frame; clr_overrun -> overrun=0.
REQ-038 RX low pulse of 1 cycle with divisor=15 -> no push, rx_valid stays 0.
REQ-039 Assert rst at TX data bit 3 -> TX=1 next cycle, tx_ready=1 after release, RX FIFO empty.

Source files
------------

// File: rtl/rv_uart_fifo.sv
// UART transmitter and receiver with a receive FIFO. Both directions share one
// bit-period divisor and a frame format that each FSM latches when a frame starts.
//
// TX states:                          RX states:
// state     | meaning                 state     | meaning
// TX_IDLE   | line high, tx_ready=1   RX_IDLE   | waiting for a falling edge
// TX_START  | driving start bit       RX_START  | start bit, glitch check
// TX_DATA   | driving data, LSB first RX_DATA   | sampling data, LSB first
// TX_PARITY | driving parity bit      RX_PARITY | sampling parity
// TX_STOP1  | first stop bit          RX_STOP1  | first stop bit
// TX_STOP2  | second stop bit         RX_STOP2  | second stop bit
module rv_uart_fifo #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int DIV_W      = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [DIV_W-1:0]              divisor,
   input  logic                          parity_en,
   input  logic                          parity_odd,
   input  logic                          two_stop,
   input  logic [DATA_BITS-1:0]          tx_data,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   output logic                          TX,
   input  logic                          RX,
   output logic [DATA_BITS-1:0]          rx_data,
   output logic                          rx_perr,
   output logic                          rx_ferr,
   output logic                          rx_valid,
   input  logic                          rx_ready,
   output logic [$clog2(FIFO_DEPTH):0]   rx_count,
   output logic                          overrun,
   input  logic                          clr_overrun
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [3:0]    LAST_BIT = 4'(DATA_BITS - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP1, RX_STOP2
   } rx_state_t;

   tx_state_t            tx_state;
   logic [DIV_W-1:0]     tx_cnt;
   logic [3:0]           tx_idx;
   logic [DATA_BITS-1:0] tx_sh;
   logic                 tx_par;
   logic                 tx_pen;
   logic                 tx_two;
   logic                 tx_line;
   logic                 tx_tc;

   assign tx_tc    = (tx_cnt == '0);
   assign tx_ready = (tx_state == TX_IDLE) && !rst;
   assign TX       = tx_line;

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_idx   <= '0;
         tx_sh    <= '0;
         tx_par   <= 1'b0;
         tx_pen   <= 1'b0;
         tx_two   <= 1'b0;
         tx_line  <= 1'b1;
      end else if (tx_state == TX_IDLE) begin
         if (tx_valid) begin
            tx_state <= TX_START;
            tx_line  <= 1'b0;
            tx_cnt   <= divisor;
            tx_idx   <= '0;
            tx_sh    <= tx_data;
            tx_par   <= (^tx_data) ^ parity_odd;
            tx_pen   <= parity_en;
            tx_two   <= two_stop;
         end
      end else if (!tx_tc) begin
         tx_cnt <= tx_cnt - 1'b1;
      end else begin
         tx_cnt <= divisor;
         case (tx_state)
            TX_START: begin
               tx_state <= TX_DATA;
               tx_line  <= tx_sh[0];
            end
            TX_DATA: begin
               if (tx_idx == LAST_BIT) begin
                  tx_state <= tx_pen ? TX_PARITY : TX_STOP1;
                  tx_line  <= tx_pen ? tx_par : 1'b1;
               end else begin
                  tx_idx  <= tx_idx + 1'b1;
                  tx_sh   <= tx_sh >> 1;
                  tx_line <= tx_sh[1];
               end
            end
            TX_PARITY: begin
               tx_state <= TX_STOP1;
               tx_line  <= 1'b1;
            end
            TX_STOP1: tx_state <= tx_two ? TX_STOP2 : TX_IDLE;
            default:  tx_state <= TX_IDLE;
         endcase
      end
   end

   // rx_d is both the edge-detect history and the bit stream the FSM samples,
   // so the detection cycle counts as cycle 0 of the start bit.
   logic [1:0]           rx_sync;
   logic                 rx_s;
   logic                 rx_d;
   rx_state_t            rx_state;
   logic [DIV_W-1:0]     rx_cnt;
   logic [DIV_W-1:0]     rx_half;
   logic [3:0]           rx_idx;
   logic [DATA_BITS-1:0] rx_sh;
   logic                 rx_pen;
   logic                 rx_odd;
   logic                 rx_two;
   logic                 rx_perr_r;
   logic                 rx_ferr_r;
   logic                 rx_mid;
   logic                 rx_tc;
   logic                 rx_push;
   logic                 push_ferr;

   assign rx_s      = rx_sync[1];
   assign rx_half   = divisor - (divisor >> 1);
   assign rx_mid    = (rx_cnt == rx_half);
   assign rx_tc     = (rx_cnt == '0);
   assign rx_push   = rx_mid && (((rx_state == RX_STOP1) && !rx_two) || (rx_state == RX_STOP2));
   assign push_ferr = rx_ferr_r | ~rx_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_sync <= 2'b11;
         rx_d    <= 1'b1;
      end else begin
         rx_sync <= {rx_sync[0], RX};
         rx_d    <= rx_s;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_state  <= RX_IDLE;
         rx_cnt    <= '0;
         rx_idx    <= '0;
         rx_sh     <= '0;
         rx_pen    <= 1'b0;
         rx_odd    <= 1'b0;
         rx_two    <= 1'b0;
         rx_perr_r <= 1'b0;
         rx_ferr_r <= 1'b0;
      end else if (rx_state == RX_IDLE) begin
         if (rx_d && !rx_s) begin
            rx_state  <= RX_START;
            rx_cnt    <= divisor;
            rx_idx    <= '0;
            rx_pen    <= parity_en;
            rx_odd    <= parity_odd;
            rx_two    <= two_stop;
            rx_perr_r <= 1'b0;
            rx_ferr_r <= 1'b0;
         end
      end else begin
         rx_cnt <= rx_tc ? divisor : rx_cnt - 1'b1;
         case (rx_state)
            RX_START: begin
               if (rx_mid && rx_d) rx_state <= RX_IDLE;
               else if (rx_tc)     rx_state <= RX_DATA;
            end
            RX_DATA: begin
               if (rx_mid) rx_sh <= {rx_d, rx_sh[DATA_BITS-1:1]};
               if (rx_tc) begin
                  if (rx_idx == LAST_BIT) rx_state <= rx_pen ? RX_PARITY : RX_STOP1;
                  else                    rx_idx   <= rx_idx + 1'b1;
               end
            end
            RX_PARITY: begin
               if (rx_mid) rx_perr_r <= (^rx_sh) ^ rx_odd ^ rx_d;
               if (rx_tc)  rx_state  <= RX_STOP1;
            end
            RX_STOP1: begin
               if (rx_mid && !rx_two) begin
                  rx_state <= RX_IDLE;
               end else begin
                  if (rx_mid) rx_ferr_r <= push_ferr;
                  if (rx_tc)  rx_state  <= RX_STOP2;
               end
            end
            default: if (rx_mid) rx_state <= RX_IDLE;
         endcase
      end
   end

   logic [DATA_BITS+1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr;
   logic [AW-1:0]        rd_ptr;
   logic [CW-1:0]        count;
   logic                 pop;
   logic                 push_ok;
   logic                 drop;

   assign pop      = rx_ready && (count != '0);
   assign push_ok  = rx_push && ((count != FULL_CNT) || pop);
   assign drop     = rx_push && (count == FULL_CNT) && !pop;
   assign rx_valid = (count != '0);
   assign rx_count = count;
   assign {rx_ferr, rx_perr, rx_data} = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok && !rst) mem[wr_ptr] <= {push_ferr, rx_perr_r, rx_sh};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         overrun <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push_ok) - CW'(pop);
         if (drop)             overrun <= 1'b1;
         else if (clr_overrun) overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rv_uart_fifo.sv
// Directed-plus-random bench for rv_uart_fifo: TX waveforms and RX frames are
// checked against a frame-level model (bit lists, a bounded entry queue).
module tb_rv_uart_fifo;
   localparam int DB    = 8;
   localparam int DEPTH = 4;
   localparam int DW    = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] divisor;
   logic          parity_en, parity_odd, two_stop;
   logic [DB-1:0] tx_data;
   logic          tx_valid, tx_ready, tx_o;
   logic          rx_line, rx_drv;
   bit            loop;
   logic [DB-1:0] rx_data;
   logic          rx_perr, rx_ferr, rx_valid, rx_ready;
   logic [2:0]    rx_count;
   logic          overrun, clr_overrun;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [7:0] d;
      bit         pe;
      bit         fe;
   } ent_t;
   ent_t q[$];
   bit   model_ovr = 1'b0;

   always #5 clk = ~clk;
   assign rx_line = loop ? tx_o : rx_drv;

   rv_uart_fifo #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH), .DIV_W(DW)) dut (
      .clk(clk), .rst(rst), .divisor(divisor),
      .parity_en(parity_en), .parity_odd(parity_odd), .two_stop(two_stop),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .TX(tx_o), .RX(rx_line),
      .rx_data(rx_data), .rx_perr(rx_perr), .rx_ferr(rx_ferr),
      .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_count(rx_count),
      .overrun(overrun), .clr_overrun(clr_overrun)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_push(input logic [7:0] d, input bit pe, input bit fe);
      ent_t e;
      e.d = d; e.pe = pe; e.fe = fe;
      if (q.size() >= DEPTH) model_ovr = 1'b1;
      else q.push_back(e);
   endfunction

   task automatic set_mode(input bit pen, input bit odd, input bit two, input int div);
      logic [31:0] dv;
      dv = 32'(div);
      divisor    = dv[DW-1:0];
      parity_en  = pen;
      parity_odd = odd;
      two_stop   = two;
   endtask

   task automatic tx_frame(input logic [7:0] d, input bit pen, input bit odd, input bit two, input int div);
      bit bits[$];
      int n;
      set_mode(pen, odd, two, div);
      tx_data = d;
      n = 0;
      while (tx_ready !== 1'b1 && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("tx_ready_idle", 32'(tx_ready), 32'd1);
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(d[i]);
      if (pen) bits.push_back((^d) ^ odd);
      bits.push_back(1'b1);
      if (two) bits.push_back(1'b1);
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      for (int k = 0; k < bits.size(); k++) begin
         for (int c = 0; c <= div; c++) begin
            if (k != 0 || c != 0) @(negedge clk);
            chk("tx_bit", 32'(tx_o), 32'(bits[k]));
            if (c == 0) chk("tx_busy", 32'(tx_ready), 32'd0);
         end
      end
      @(negedge clk);
      chk("tx_ready_after", 32'(tx_ready), 32'd1);
      chk("tx_idle_line", 32'(tx_o), 32'd1);
      if (loop) model_push(d, 1'b0, 1'b0);
   endtask

   task automatic rx_frame(input logic [7:0] d, input bit pen, input bit odd, input bit two,
                           input bit bad_par, input bit stop_v, input int div);
      bit bits[$];
      set_mode(pen, odd, two, div);
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(d[i]);
      if (pen) bits.push_back((^d) ^ odd ^ bad_par);
      bits.push_back(stop_v);
      if (two) bits.push_back(stop_v);
      for (int k = 0; k < bits.size(); k++) begin
         rx_drv = bits[k];
         repeat (div + 1) @(negedge clk);
      end
      rx_drv = 1'b1;
      repeat (2 * div + 12) @(negedge clk);
      model_push(d, pen & bad_par, !stop_v);
   endtask

   task automatic check_head();
      chk("rx_valid", 32'(rx_valid), 32'(q.size() != 0));
      chk("rx_count", 32'(rx_count), 32'(q.size()));
      if (q.size() > 0) begin
         chk("rx_data", 32'(rx_data), 32'(q[0].d));
         chk("rx_perr", 32'(rx_perr), 32'(q[0].pe));
         chk("rx_ferr", 32'(rx_ferr), 32'(q[0].fe));
      end
   endtask

   task automatic pop_one();
      check_head();
      if (q.size() > 0) begin
         rx_ready = 1'b1;
         @(negedge clk);
         rx_ready = 1'b0;
         void'(q.pop_front());
      end
      chk("rx_count_pop", 32'(rx_count), 32'(q.size()));
   endtask

   initial begin
      logic [7:0] d;
      bit pen, odd, two, bad, stp;
      int div;

      rst = 1'b1; loop = 1'b0; rx_drv = 1'b1;
      set_mode(1'b0, 1'b0, 1'b0, 3);
      tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0; clr_overrun = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_tx", 32'(tx_o), 32'd1);
      chk("rst_tx_ready", 32'(tx_ready), 32'd0);
      chk("rst_rx_valid", 32'(rx_valid), 32'd0);
      chk("rst_rx_count", 32'(rx_count), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("tx_ready_release", 32'(tx_ready), 32'd1);

      // 8N1, divisor 3, 0xA5: 10 bits of 4 cycles each, tx_ready low for 40 cycles
      tx_frame(8'hA5, 1'b0, 1'b0, 1'b0, 3);

      for (int i = 0; i < 6; i++) begin
         d = 8'($urandom);
         tx_frame(d, 1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 4)));
      end

      // loopback 8E2, divisor 7
      loop = 1'b1;
      repeat (4) @(negedge clk);
      tx_frame(8'h3C, 1'b1, 1'b0, 1'b1, 7);
      repeat (20) @(negedge clk);
      chk("loop_count", 32'(rx_count), 32'd1);
      pop_one();

      for (int i = 0; i < 3; i++) begin
         d = 8'($urandom);
         tx_frame(d, 1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 9)));
         repeat (20) @(negedge clk);
      end
      for (int i = 0; i < 3; i++) pop_one();
      loop = 1'b0;
      repeat (4) @(negedge clk);

      // 0x55 with a low stop bit
      rx_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3);
      chk("ferr_frame_data", 32'(rx_data), 32'h55);
      chk("ferr_frame_flag", 32'(rx_ferr), 32'd1);
      pop_one();

      for (int i = 0; i < 8; i++) begin
         d   = 8'($urandom);
         pen = 1'($urandom);
         odd = 1'($urandom);
         two = 1'($urandom);
         bad = 1'($urandom);
         stp = ($urandom_range(0, 3) != 0);
         div = int'($urandom_range(0, 6));
         rx_frame(d, pen, odd, two, bad, stp, div);
         pop_one();
      end

      // single-cycle low glitch at divisor 15
      set_mode(1'b0, 1'b0, 1'b0, 15);
      rx_drv = 1'b0;
      @(negedge clk);
      rx_drv = 1'b1;
      repeat (40) @(negedge clk);
      chk("glitch_rx_valid", 32'(rx_valid), 32'd0);
      chk("glitch_rx_count", 32'(rx_count), 32'd0);

      // five frames into a four-entry FIFO
      for (int i = 0; i < 5; i++) begin
         d = 8'($urandom);
         rx_frame(d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2);
      end
      chk("full_count", 32'(rx_count), 32'd4);
      chk("overrun_set", 32'(overrun), 32'(model_ovr));
      check_head();
      clr_overrun = 1'b1;
      @(negedge clk);
      clr_overrun = 1'b0;
      model_ovr = 1'b0;
      chk("overrun_clr", 32'(overrun), 32'(model_ovr));
      while (q.size() > 0) pop_one();

      rx_ready = 1'b1;
      repeat (2) @(negedge clk);
      rx_ready = 1'b0;
      chk("pop_empty_count", 32'(rx_count), 32'd0);
      chk("pop_empty_valid", 32'(rx_valid), 32'd0);

      // reset during data bit 3 of a looped-back frame
      loop = 1'b1;
      set_mode(1'b0, 1'b0, 1'b0, 3);
      tx_data = 8'hC3;
      @(negedge clk);
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      repeat (16) @(negedge clk);
      chk("abort_bit3", 32'(tx_o), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_tx_high", 32'(tx_o), 32'd1);
      chk("abort_tx_ready_rst", 32'(tx_ready), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("abort_tx_ready", 32'(tx_ready), 32'd1);
      repeat (60) @(negedge clk);
      chk("abort_rx_valid", 32'(rx_valid), 32'd0);
      chk("abort_rx_count", 32'(rx_count), 32'd0);
      chk("abort_line", 32'(tx_o), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
